// File: rtl/piso_serial_tx_if.sv
// piso_serial_tx_if: word handshake plus serial line and status of the framed transmitter
interface piso_serial_tx_if #(parameter int DATA_WIDTH = 8);
   logic [DATA_WIDTH-1:0] din;
   logic din_valid, din_ready, tx, busy, done;
   modport master (output din, din_valid, input din_ready, tx, busy, done);
   modport slave (input din, din_valid, output din_ready, tx, busy, done);
endinterface

// File: rtl/piso_serial_tx.sv
// piso_serial_tx: LSB-first framed serializer with start bit 0, stop bit 1, each bit held CLKS_PER_BIT clocks
module piso_serial_tx #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input logic clk,
   input logic rst,
   piso_serial_tx_if.slave s
);
   localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
   localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t state, state_n;
   logic [DATA_WIDTH-1:0] shift, shift_n;
   logic [BW-1:0] bit_cnt, bit_cnt_n;
   logic [CW-1:0] clk_cnt, clk_cnt_n;
   logic tx_n, ready_n, busy_n, done_n, last;
   assign last = clk_cnt == CW'(CLKS_PER_BIT - 1);
   always_comb begin
      state_n   = state;
      shift_n   = shift;
      bit_cnt_n = bit_cnt;
      clk_cnt_n = last ? '0 : clk_cnt + 1'b1;
      tx_n      = s.tx;
      ready_n   = s.din_ready;
      busy_n    = s.busy;
      done_n    = 1'b0;
      case (state)
         IDLE: begin
            clk_cnt_n = '0;
            tx_n      = 1'b1;
            ready_n   = 1'b1;
            busy_n    = 1'b0;
            if (s.din_valid) begin
               shift_n = s.din;
               state_n = START;
               tx_n    = 1'b0;
               ready_n = 1'b0;
               busy_n  = 1'b1;
            end
         end
         START: if (last) begin
            state_n   = DATA;
            tx_n      = shift[0];
            bit_cnt_n = '0;
         end
         DATA: if (last) begin
            if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
               state_n = STOP;
               tx_n    = 1'b1;
            end else begin
               shift_n   = shift >> 1;
               tx_n      = shift_n[0];
               bit_cnt_n = bit_cnt + 1'b1;
            end
         end
         STOP: if (last) begin
            state_n = IDLE;
            ready_n = 1'b1;
            busy_n  = 1'b0;
            done_n  = 1'b1;
         end
         default: begin
            state_n   = IDLE;
            clk_cnt_n = '0;
            tx_n      = 1'b1;
            ready_n   = 1'b1;
            busy_n    = 1'b0;
         end
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         shift       <= '0;
         bit_cnt     <= '0;
         clk_cnt     <= '0;
         s.tx        <= 1'b1;
         s.din_ready <= 1'b1;
         s.busy      <= 1'b0;
         s.done      <= 1'b0;
      end else begin
         state       <= state_n;
         shift       <= shift_n;
         bit_cnt     <= bit_cnt_n;
         clk_cnt     <= clk_cnt_n;
         s.tx        <= tx_n;
         s.din_ready <= ready_n;
         s.busy      <= busy_n;
         s.done      <= done_n;
      end
   end
endmodule

// File: tb/tb_piso_serial_tx.sv
// tb_piso_serial_tx: frame-position model checks two transmitters (4 and 1 clocks per bit) every cycle
module tb_piso_serial_tx;
   logic clk = 1'b0, rst = 1'b0, din_valid = 1'b0, sel = 1'b0;
   logic [7:0] din = 8'h00;
   always #5 clk = ~clk;
   piso_serial_tx_if #(.DATA_WIDTH(8)) i0 (), i1 ();
   assign i0.din = din;
   assign i0.din_valid = din_valid;
   assign i1.din = din;
   assign i1.din_valid = din_valid;
   piso_serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) u0 (.clk(clk), .rst(rst), .s(i0));
   piso_serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) u1 (.clk(clk), .rst(rst), .s(i1));
   logic [1:0] a_tx, a_rdy, a_busy, a_done;
   assign a_tx   = {i1.tx, i0.tx};
   assign a_rdy  = {i1.din_ready, i0.din_ready};
   assign a_busy = {i1.busy, i0.busy};
   assign a_done = {i1.done, i0.done};
   logic stx, srdy, sbusy, sdone;
   assign stx   = sel ? i1.tx : i0.tx;
   assign srdy  = sel ? i1.din_ready : i0.din_ready;
   assign sbusy = sel ? i1.busy : i0.busy;
   assign sdone = sel ? i1.done : i0.done;
   int passed = 0, total = 0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask
   // pos = cycles since capture edge, -1 when idle; a frame spans 10*cpb cycles
   int pos[2] = '{-1, -1};
   int cpb[2] = '{4, 1};
   logic [7:0] word[2] = '{8'h00, 8'h00};
   logic md[2] = '{1'b0, 1'b0};
   bit run = 1'b0;
   always @(posedge clk)
      for (int d = 0; d < 2; d++) begin
         md[d] = 1'b0;
         if (!rst) pos[d] = -1;
         else if (pos[d] < 0) begin
            if (din_valid) begin
               word[d] = din;
               pos[d] = 0;
            end
         end else begin
            pos[d] = pos[d] + 1;
            if (pos[d] == 10 * cpb[d]) begin
               pos[d] = -1;
               md[d] = 1'b1;
            end
         end
      end
   function automatic logic etx(input int p, input logic [7:0] w, input int c);
      int i;
      if (p < 0) return 1'b1;
      i = p / c;
      if (i == 0) return 1'b0;
      if (i <= 8) return w[i-1];
      return 1'b1;
   endfunction
   always @(negedge clk)
      if (run)
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("tx%0d", d), 32'(a_tx[d]), 32'(etx(pos[d], word[d], cpb[d])));
            chk($sformatf("ready%0d", d), 32'(a_rdy[d]), 32'(pos[d] < 0));
            chk($sformatf("busy%0d", d), 32'(a_busy[d]), 32'(pos[d] >= 0));
            chk($sformatf("done%0d", d), 32'(a_done[d]), 32'(md[d]));
         end
   task automatic send(input logic [7:0] w);
      @(negedge clk);
      din = w;
      din_valid = 1'b1;
   endtask
   task automatic frame_obs(input string tag, input int c, input int mode, output logic [9:0] bits);
      int nb, nd, nr;
      nb = 0; nd = 0; nr = 0; bits = '0;
      for (int k = 0; k < 10 * c; k++) begin
         @(negedge clk);
         if (k == 0 && mode != 1) din_valid = 1'b0;
         if (k == 0 && mode == 1) din = 8'hF0;
         if (k == 0) chk({tag, "_start"}, 32'(stx), 32'd0);
         if (mode == 2 && k == 10) begin
            din_valid = 1'b1;
            din = 8'hFF;
         end
         if (mode == 2 && k == 20) din_valid = 1'b0;
         if (k % c == c / 2) bits[k/c] = stx;
         nb += int'(sbusy);
         nd += int'(sdone);
         nr += int'(srdy);
      end
      @(negedge clk);
      chk({tag, "_busy_cycles"}, 32'(nb), 32'(10 * c));
      chk({tag, "_done_early"}, 32'(nd), 32'd0);
      chk({tag, "_ready_in_frame"}, 32'(nr), 32'd0);
      chk({tag, "_done_end"}, 32'(sdone), 32'd1);
      chk({tag, "_tx_gap"}, 32'(stx), 32'd1);
      chk({tag, "_ready_gap"}, 32'(srdy), 32'd1);
   endtask
   initial begin
      logic [9:0] b;
      int nd;
      din_valid = 1'b1;
      din = 8'hFF;
      @(posedge clk);
      run = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rst_tx", 32'(stx), 32'd1);
      chk("rst_ready", 32'(srdy), 32'd1);
      chk("rst_busy", 32'(sbusy), 32'd0);
      chk("rst_done", 32'(sdone), 32'd0);
      rst = 1'b1;
      din_valid = 1'b0;
      @(negedge clk);
      chk("rst_no_frame", 32'(sbusy), 32'd0);
      send(8'hA5);
      frame_obs("a5", 4, 0, b);
      chk("a5_bits", 32'(b), 32'(10'b1101001010));
      repeat (3) @(negedge clk);
      send(8'h0F);
      frame_obs("b2b0", 4, 1, b);
      chk("b2b0_bits", 32'(b), 32'(10'b1000011110));
      frame_obs("b2b1", 4, 0, b);
      chk("b2b1_bits", 32'(b), 32'(10'b1111100000));
      repeat (20) @(negedge clk);
      send(8'h3C);
      frame_obs("ign", 4, 2, b);
      chk("ign_bits", 32'(b), 32'(10'b1001111000));
      repeat (5) @(negedge clk);
      chk("ign_no_extra", 32'(sbusy), 32'd0);
      repeat (20) @(negedge clk);
      send(8'h55);
      repeat (18) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      din_valid = 1'b0;
      chk("mid_rst_tx", 32'(stx), 32'd1);
      chk("mid_rst_busy", 32'(sbusy), 32'd0);
      chk("mid_rst_ready", 32'(srdy), 32'd1);
      nd = 0;
      repeat (50) begin
         @(negedge clk);
         nd += int'(sdone);
      end
      chk("mid_rst_no_done", 32'(nd), 32'd0);
      send(8'h01);
      frame_obs("r01", 4, 0, b);
      chk("r01_bits", 32'(b), 32'(10'b1000000010));
      repeat (20) @(negedge clk);
      sel = 1'b1;
      send(8'h80);
      frame_obs("c1", 1, 0, b);
      chk("c1_bits", 32'(b), 32'(10'b1100000000));
      repeat (50) @(negedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/piso_serial_tx.md
Name: piso_serial_tx

Overview:
- Parallel-in, serial-out framed transmitter. It is the sending end of the single-wire serial link whose receiving end is a shift-register receiver.
- Accepts a DATA_WIDTH-bit word over a valid/ready handshake and shifts it out LSB-first on one line.
- Framing: a start bit (0) before the data and a stop bit (1) after it. Each bit is held for CLKS_PER_BIT clocks.
- Sits between a word producer (counter, FSM or bench) and the serial line of the deserializer block.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (>=1).
- CLKS_PER_BIT, 4, clock cycles each serial bit is held (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset: synchronous, active-low. Asserted when 0, sampled only on the rising edge of clk.
- din  input  DATA_WIDTH  parallel word to transmit.
- din_valid  input  1  producer has a word on din.
- din_ready  output  1  transmitter can accept a word.
- tx  output  1  serial line; idles high.
- busy  output  1  a frame is in progress (START, DATA or STOP state).
- done  output  1  one-cycle pulse at the end of the stop bit.

Behaviour:
- All outputs are registered and all state updates on the rising edge of clk.
- Reset (rst==0 at an edge):
  - state=IDLE, tx=1, din_ready=1, busy=0, done=0.
  - Shift register and counters cleared.
  - Overrides every other input. A frame in flight is aborted and its data discarded; tx is 1 after that edge.
- States: IDLE, START, DATA, STOP.
  - bit_cnt counts 0..DATA_WIDTH-1. Width is $clog2(DATA_WIDTH), minimum 1.
  - clk_cnt counts 0..CLKS_PER_BIT-1. Width is $clog2(CLKS_PER_BIT), minimum 1.
- IDLE:
  - tx=1, din_ready=1, busy=0.
  - On an edge with din_valid&&din_ready: latch din into the shift register, state->START, tx<=0, din_ready<=0, busy<=1, clk_cnt<=0.
- START:
  - tx=0 for CLKS_PER_BIT cycles.
  - When clk_cnt==CLKS_PER_BIT-1: state->DATA, tx<=shift[0], bit_cnt<=0, clk_cnt<=0.
- DATA:
  - Each bit is held CLKS_PER_BIT cycles.
  - When clk_cnt==CLKS_PER_BIT-1 and bit_cnt<DATA_WIDTH-1: shift right, tx<=next bit, bit_cnt++.
  - When bit_cnt==DATA_WIDTH-1: state->STOP, tx<=1.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - At the final edge: state->IDLE, din_ready<=1, busy<=0, done<=1 for exactly one cycle.
- Frame length: (DATA_WIDTH+2)*CLKS_PER_BIT cycles from the capture edge to the done edge.
- Minimum gap between frames: one IDLE cycle with tx=1.
  - With din_valid held high, the next word is captured at the edge after done rises.
- din_valid while din_ready==0: ignored. No capture, no side effects.
- din changes during a frame: no effect, because the word is latched at capture.
- CLKS_PER_BIT==1: each state bit lasts one cycle. Same transitions, counters degenerate to 0.
- Counters wrap only through the explicit transitions above. No state is reachable other than the four listed; any illegal encoding returns to IDLE with tx=1.

Test Plan:
- Reset: rst=0 for 2 edges with din_valid=1, din=8'hFF -> tx=1, din_ready=1, busy=0, done=0, and no frame starts.
- Single frame: DATA_WIDTH=8, CLKS_PER_BIT=4, din=8'hA5 with one valid pulse.
  - tx bit sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles.
  - busy high for 40 cycles; done pulses once, 40 cycles after the capture edge.
- Back-to-back: din_valid held high with 8'h0F then 8'hF0.
  - Exactly one tx=1 idle cycle between frames.
  - Second frame data bits are 0,0,0,0,1,1,1,1.
  - din_ready low throughout both frames.
- Ignored valid: during a frame of 8'h3C, assert din_valid with din=8'hFF -> frame still serializes 8'h3C, and no extra frame follows.
- Reset mid-frame: rst=0 at the edge during data bit 3 of 8'h55.
  - tx=1, busy=0, din_ready=1 after that edge.
  - done never pulses; the next frame (8'h01) transmits correctly.
- CLKS_PER_BIT=1, din=8'h80 -> tx sequence 0,0,0,0,0,0,0,0,1,1 on consecutive cycles; done 10 cycles after capture.
